ca_sram_arbiter: RTL and testbench
==================================

CA_SRAM_ARBITER -- requirements
Module: ca_sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM data width.
REQ-003 SHALL have parameter MAX_WAIT, default 1023, CA-wait cycles before the starvation flag sets.
REQ-004 iCLK  input  1  single clock, VGA_CTRL_CLK domain; all logic rising-edge.
REQ-005 iRST_N  input  1  reset, synchronous and active-low.
REQ-006 iVGA_REQ  input  1  VGA pixel-fetch read request.
REQ-007 iVGA_ADDR  input  ADDR_W  VGA read address.
REQ-008 oVGA_DATA  output  DATA_W  VGA read data.
REQ-009 oVGA_VALID  output  1  oVGA_DATA valid, one-cycle pulse.
REQ-010 iCA_REQ  input  1  CA engine access request, held until granted.
REQ-011 iCA_WE  input  1  1 = write, 0 = read; qualified by iCA_REQ.
REQ-012 iCA_ADDR  input  ADDR_W  CA access address.
REQ-013 iCA_WDATA  input  DATA_W  CA write data.
REQ-014 oCA_GNT  output  1  CA request accepted, one-cycle pulse.
REQ-015 oCA_RDATA  output  DATA_W  CA read data.
REQ-016 oCA_RVALID  output  1  oCA_RDATA valid, one-cycle pulse.
REQ-017 oCA_STARVE  output  1  CA has waited at least MAX_WAIT cycles.
REQ-018 oSRAM_ADDR  output  ADDR_W  SRAM address, registered.
REQ-019 oSRAM_DQ  output  DATA_W  SRAM write data, registered.
REQ-020 oSRAM_DQ_OE  output  1  DQ output enable; the top level tristates SRAM_DQ when this is 0.
REQ-021 iSRAM_DQ  input  DATA_W  SRAM read data.
REQ-022 oSRAM_WE_N, oSRAM_OE_N, oSRAM_CE_N, oSRAM_UB_N, oSRAM_LB_N  output  1 each  SRAM strobes, active-low, registered.

Function
REQ-023 SHALL implement the states IDLE, VGA_RD, CA_RD, CA_WR and TURN.
REQ-024 Arbitration SHALL be evaluated every cycle in IDLE, VGA_RD, CA_RD and TURN, with VGA strictly above CA.
- iVGA_REQ=1 -> VGA_RD.
- Else iCA_REQ=1 and TURN not required -> CA_RD (iCA_WE=0) or CA_WR (iCA_WE=1).
- Else -> IDLE.
REQ-025 On entering CA_RD/CA_WR, oCA_GNT SHALL pulse in that same cycle; iCA_ADDR, iCA_WE and iCA_WDATA SHALL be captured on that edge.
REQ-026 Read latency SHALL be fixed for both VGA and CA reads.
- Request sampled at edge N; oSRAM_ADDR/OE_N driven during cycle N+1.
- iSRAM_DQ captured at edge N+2; oVGA_VALID or oCA_RVALID high during cycle N+2.
REQ-027 Back-to-back VGA reads SHALL sustain one read per cycle with no bubbles.
REQ-028 CA_WR SHALL assert oSRAM_WE_N=0 and oSRAM_DQ_OE=1 for exactly one cycle; oSRAM_OE_N=1 throughout CA_WR.
REQ-029 After CA_WR, the FSM SHALL spend one cycle in TURN if the next access is a read.
- oSRAM_DQ_OE=0 and all strobes inactive in TURN.
- CA_WR -> CA_WR SHALL be allowed directly.
REQ-030 A CA write SHALL never be issued while iVGA_REQ=1; a VGA request arriving during CA_WR waits at most 2 cycles (CA_WR, then TURN).
REQ-031 oSRAM_CE_N, oSRAM_UB_N and oSRAM_LB_N SHALL be 0 in VGA_RD, CA_RD and CA_WR, and 1 in IDLE and TURN.
REQ-032 The wait counter SHALL increment each cycle iCA_REQ=1 without grant, saturate at MAX_WAIT, and clear on oCA_GNT.
REQ-033 oCA_STARVE=1 SHALL hold while wait counter == MAX_WAIT; it is status only and SHALL NOT alter priority.
REQ-034 Simultaneous iVGA_REQ and iCA_REQ: VGA served, CA held; no CA request lost or duplicated.
REQ-035 oVGA_VALID and oCA_RVALID SHALL never be high in the same cycle.

Reset
REQ-036 While iRST_N=0 at an edge, the FSM SHALL return to IDLE from any state, including mid-write.
REQ-037 Reset values: oSRAM_WE_N/OE_N/CE_N/UB_N/LB_N=1, oSRAM_DQ_OE=0, oSRAM_ADDR=0, oSRAM_DQ=0, all valid/grant/starve outputs=0, data outputs=0, wait counter=0.
REQ-038 Read responses in flight at reset SHALL be discarded, with no valid pulse after reset.

Structure
REQ-039 The state encoding and the SRAM strobe-bundle typedef SHALL live in shared package ca_pkg, with ADDR_W/DATA_W default constants.
REQ-040 The saturating wait counter SHALL be sub-module ca_wait_counter; everything else is flat.

Verification
REQ-041 Reset, then VGA read addr 0x00010 with SRAM model returning 0xBEEF -> oVGA_VALID exactly 2 cycles later with oVGA_DATA=0xBEEF.
REQ-042 VGA requests 640 consecutive cycles while CA write is pending -> 640 VGA_VALIDs with no gaps; CA granted the cycle after iVGA_REQ falls.
REQ-043 CA write 0x1234 to 0x00100, then CA read of 0x00100 -> one TURN cycle observed; oCA_RDATA=0x1234.
REQ-044 CA held off 1023+ cycles by VGA -> oCA_STARVE=1 from wait cycle 1023; clears on the cycle after oCA_GNT.
REQ-045 iRST_N=0 during CA_WR -> next cycle all strobes=1, oSRAM_DQ_OE=0, no CA_RVALID/GNT pulse.
REQ-046 Random VGA/CA traffic with SRAM scoreboard -> no OE_N=0 while DQ_OE=1, no lost CA requests, valids never concurrent.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared types for the CA / VGA SRAM arbiter: FSM state encoding, the SRAM
// strobe bundle and the default bus widths.
package ca_pkg;

    localparam int CA_ADDR_W = 18;
    localparam int CA_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VGA_RD = 3'd1,
        ST_CA_RD  = 3'd2,
        ST_CA_WR  = 3'd3,
        ST_TURN   = 3'd4
    } ca_state_t;

    // Active-low SRAM strobes plus the DQ output enable, registered as one bundle.
    typedef struct packed {
        logic we_n;
        logic oe_n;
        logic ce_n;
        logic ub_n;
        logic lb_n;
        logic dq_oe;
    } sram_strb_t;

    localparam sram_strb_t STRB_IDLE = '{we_n: 1'b1, oe_n: 1'b1, ce_n: 1'b1,
                                         ub_n: 1'b1, lb_n: 1'b1, dq_oe: 1'b0};

    // Strobe pattern to present on the SRAM pins while the FSM sits in a state.
    function automatic sram_strb_t strobes_for(input ca_state_t st);
        sram_strb_t b;
        b = STRB_IDLE;
        case (st)
            ST_VGA_RD, ST_CA_RD: begin
                b.oe_n = 1'b0;
                b.ce_n = 1'b0;
                b.ub_n = 1'b0;
                b.lb_n = 1'b0;
            end
            ST_CA_WR: begin
                b.we_n  = 1'b0;
                b.ce_n  = 1'b0;
                b.ub_n  = 1'b0;
                b.lb_n  = 1'b0;
                b.dq_oe = 1'b1;
            end
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ca_wait_counter.sv
// Saturating count of cycles the CA engine has been kept waiting; raises a
// status flag once the count reaches MAX_WAIT.
module ca_wait_counter #(
    parameter int MAX_WAIT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic starve
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt;

    // Clear has priority; otherwise count waiting cycles up to the ceiling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign starve = (cnt == CNT_MAX);

endmodule

// File: rtl/ca_sram_arbiter.sv
// Single-port async SRAM arbiter: VGA pixel fetch has strict priority over the
// CA engine. All SRAM pins are registered; reads return two cycles after the
// request is sampled.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | bus parked, all strobes inactive
// ST_VGA_RD | VGA read address on the bus, OE_N low
// ST_CA_RD  | CA read address on the bus, OE_N low
// ST_CA_WR  | CA write: WE_N low and DQ driven for this one cycle
// ST_TURN   | bus turnaround after a write before any read, strobes off
module ca_sram_arbiter
    import ca_pkg::*;
#(
    parameter int ADDR_W   = CA_ADDR_W,
    parameter int DATA_W   = CA_DATA_W,
    parameter int MAX_WAIT = 1023
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iVGA_REQ,
    input  logic [ADDR_W-1:0] iVGA_ADDR,
    output logic [DATA_W-1:0] oVGA_DATA,
    output logic              oVGA_VALID,
    input  logic              iCA_REQ,
    input  logic              iCA_WE,
    input  logic [ADDR_W-1:0] iCA_ADDR,
    input  logic [DATA_W-1:0] iCA_WDATA,
    output logic              oCA_GNT,
    output logic [DATA_W-1:0] oCA_RDATA,
    output logic              oCA_RVALID,
    output logic              oCA_STARVE,
    output logic [ADDR_W-1:0] oSRAM_ADDR,
    output logic [DATA_W-1:0] oSRAM_DQ,
    output logic              oSRAM_DQ_OE,
    input  logic [DATA_W-1:0] iSRAM_DQ,
    output logic              oSRAM_WE_N,
    output logic              oSRAM_OE_N,
    output logic              oSRAM_CE_N,
    output logic              oSRAM_UB_N,
    output logic              oSRAM_LB_N
);

    ca_state_t  state;
    ca_state_t  next_state;
    sram_strb_t strb;
    logic       ca_take;

    // Arbitration: VGA first, then CA; a read following a write must pass TURN.
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_CA_WR: begin
                if (iVGA_REQ) begin
                    next_state = ST_TURN;
                end else if (iCA_REQ) begin
                    next_state = iCA_WE ? ST_CA_WR : ST_TURN;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                if (iVGA_REQ) begin
                    next_state = ST_VGA_RD;
                end else if (iCA_REQ) begin
                    next_state = iCA_WE ? ST_CA_WR : ST_CA_RD;
                end else begin
                    next_state = ST_IDLE;
                end
            end
        endcase
    end

    assign ca_take = (next_state == ST_CA_RD) || (next_state == ST_CA_WR);

    // State, strobes, grant and SRAM address/data all launch on the decision edge.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state      <= ST_IDLE;
            strb       <= STRB_IDLE;
            oCA_GNT    <= 1'b0;
            oSRAM_ADDR <= '0;
            oSRAM_DQ   <= '0;
        end else begin
            state   <= next_state;
            strb    <= strobes_for(next_state);
            oCA_GNT <= ca_take;
            if (next_state == ST_VGA_RD) begin
                oSRAM_ADDR <= iVGA_ADDR;
            end else if (ca_take) begin
                oSRAM_ADDR <= iCA_ADDR;
            end
            if (next_state == ST_CA_WR) begin
                oSRAM_DQ <= iCA_WDATA;
            end
        end
    end

    // Capture SRAM read data at the end of the read cycle; at most one read is in flight.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            oVGA_VALID <= 1'b0;
            oVGA_DATA  <= '0;
            oCA_RVALID <= 1'b0;
            oCA_RDATA  <= '0;
        end else begin
            oVGA_VALID <= (state == ST_VGA_RD);
            oCA_RVALID <= (state == ST_CA_RD);
            if (state == ST_VGA_RD) begin
                oVGA_DATA <= iSRAM_DQ;
            end
            if (state == ST_CA_RD) begin
                oCA_RDATA <= iSRAM_DQ;
            end
        end
    end

    assign oSRAM_WE_N  = strb.we_n;
    assign oSRAM_OE_N  = strb.oe_n;
    assign oSRAM_CE_N  = strb.ce_n;
    assign oSRAM_UB_N  = strb.ub_n;
    assign oSRAM_LB_N  = strb.lb_n;
    assign oSRAM_DQ_OE = strb.dq_oe;

    ca_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk    (iCLK),
        .rst_n  (iRST_N),
        .inc    (iCA_REQ && !ca_take),
        .clr    (oCA_GNT),
        .starve (oCA_STARVE)
    );

endmodule

// File: tb/tb_ca_sram_arbiter.sv
// Directed bench for ca_sram_arbiter with a behavioural async SRAM model.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_ca_sram_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;
    // {we_n, oe_n, ce_n, ub_n, lb_n, dq_oe}
    localparam logic [5:0] S_IDLE = 6'b111110;
    localparam logic [5:0] S_RD   = 6'b100000;
    localparam logic [5:0] S_WR   = 6'b010001;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          vga_valid;
    logic          ca_req;
    logic          ca_we;
    logic [AW-1:0] ca_addr;
    logic [DW-1:0] ca_wdata;
    logic          ca_gnt;
    logic [DW-1:0] ca_rdata;
    logic          ca_rvalid;
    logic          ca_starve;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dq_out;
    logic          sram_dq_oe;
    logic [DW-1:0] sram_dq_in = '0;
    logic          we_n, oe_n, ce_n, ub_n, lb_n;

    logic [DW-1:0] wr_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    ca_sram_arbiter dut (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .iVGA_REQ    (vga_req),
        .iVGA_ADDR   (vga_addr),
        .oVGA_DATA   (vga_data),
        .oVGA_VALID  (vga_valid),
        .iCA_REQ     (ca_req),
        .iCA_WE      (ca_we),
        .iCA_ADDR    (ca_addr),
        .iCA_WDATA   (ca_wdata),
        .oCA_GNT     (ca_gnt),
        .oCA_RDATA   (ca_rdata),
        .oCA_RVALID  (ca_rvalid),
        .oCA_STARVE  (ca_starve),
        .oSRAM_ADDR  (sram_addr),
        .oSRAM_DQ    (sram_dq_out),
        .oSRAM_DQ_OE (sram_dq_oe),
        .iSRAM_DQ    (sram_dq_in),
        .oSRAM_WE_N  (we_n),
        .oSRAM_OE_N  (oe_n),
        .oSRAM_CE_N  (ce_n),
        .oSRAM_UB_N  (ub_n),
        .oSRAM_LB_N  (lb_n)
    );

    always #5 clk = ~clk;

    // Background SRAM contents: address-derived, with one planted word at 0x10.
    function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
        if (a == 18'h00010) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (wr_mem.exists(a)) return wr_mem[a];
        return f(a);
    endfunction

    // SRAM write: takes place at the edge that ends a WE_N-low cycle.
    always @(posedge clk) begin
        if (!we_n && !ce_n && sram_dq_oe) wr_mem[sram_addr] = sram_dq_out;
    end

    // SRAM read: data settles mid-cycle from the registered address.
    always @(negedge clk) begin
        sram_dq_in <= (!oe_n && !ce_n && !sram_dq_oe) ? model_rd(sram_addr) : '0;
    end

    function automatic logic [5:0] strb();
        return {we_n, oe_n, ce_n, ub_n, lb_n, sram_dq_oe};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n_vld, bad, early, sgnt;
        int issued, granted, dup_err, rd_err, conc_err, oe_err, timeout, wait_cyc;
        logic [DW-1:0] exp_d;

        // Reset with both requesters active: reset must win.
        rst_n = 1'b0; vga_req = 1'b1; vga_addr = '0;
        ca_req = 1'b1; ca_we = 1'b1; ca_addr = '0; ca_wdata = 16'hFFFF;
        tick; tick;
        check("rst_strobes", strb(), S_IDLE);
        check("rst_addr", sram_addr, 0);
        check("rst_dq", sram_dq_out, 0);
        check("rst_flags", {vga_valid, ca_gnt, ca_rvalid, ca_starve}, 0);
        check("rst_data", {vga_data, ca_rdata}, 0);
        rst_n = 1'b1; vga_req = 1'b0; ca_req = 1'b0;
        tick;

        // Single VGA read of 0x00010: valid two cycles after the request.
        vga_req = 1'b1; vga_addr = 18'h00010;
        tick;
        vga_req = 1'b0;
        check("vga_rd_strb", strb(), S_RD);
        check("vga_rd_addr", sram_addr, 18'h00010);
        check("vga_valid_early", vga_valid, 0);
        tick;
        check("vga_valid", vga_valid, 1);
        check("vga_data", vga_data, 16'hBEEF);
        tick;
        check("vga_valid_pulse", vga_valid, 0);
        check("idle_strb", strb(), S_IDLE);

        // 640 back-to-back VGA reads with a CA write held pending.
        ca_req = 1'b1; ca_we = 1'b1; ca_addr = 18'h00200; ca_wdata = 16'h7777;
        vga_req = 1'b1;
        n_vld = 0; bad = 0; early = 0;
        for (int i = 0; i <= 640; i++) begin
            if (i < 640) vga_addr = 18'h01000 + 18'(i);
            else vga_req = 1'b0;
            tick;
            if (i >= 1) begin
                if (vga_valid) begin
                    n_vld++;
                    if (vga_data !== f(18'h01000 + 18'(i - 1))) bad++;
                end
            end else if (vga_valid) begin
                bad++;
            end
            if ((i < 640) && ca_gnt) early++;
        end
        check("burst_valid_count", n_vld, 640);
        check("burst_bad_data", bad, 0);
        check("burst_early_gnt", early, 0);
        check("burst_gnt_after", ca_gnt, 1);
        check("burst_wr_strb", strb(), S_WR);
        check("burst_wr_addr_dq", {sram_addr, sram_dq_out}, {18'h00200, 16'h7777});
        ca_req = 1'b0;
        tick;
        check("burst_wr_done_strb", strb(), S_IDLE);
        check("burst_wr_gnt_pulse", ca_gnt, 0);
        check("burst_wr_mem", model_rd(18'h00200), 16'h7777);

        // Write -> write direct, write 0x1234 to 0x100, then read it back via TURN.
        ca_req = 1'b1; ca_we = 1'b1; ca_addr = 18'h00300; ca_wdata = 16'hAAAA;
        tick;
        check("ww_gnt1", ca_gnt, 1);
        check("ww_addr1", {sram_addr, sram_dq_out, strb()}, {18'h00300, 16'hAAAA, S_WR});
        ca_addr = 18'h00301; ca_wdata = 16'hBBBB;
        tick;
        check("ww_gnt2", ca_gnt, 1);
        check("ww_addr2", {sram_addr, sram_dq_out, strb()}, {18'h00301, 16'hBBBB, S_WR});
        ca_addr = 18'h00100; ca_wdata = 16'h1234;
        tick;
        check("ww_gnt3", ca_gnt, 1);
        check("ww_addr3", {sram_addr, sram_dq_out, strb()}, {18'h00100, 16'h1234, S_WR});
        ca_we = 1'b0;
        tick;
        check("turn_strb", strb(), S_IDLE);
        check("turn_no_gnt", ca_gnt, 0);
        tick;
        check("ca_rd_gnt", ca_gnt, 1);
        check("ca_rd_bus", {sram_addr, strb()}, {18'h00100, S_RD});
        ca_req = 1'b0;
        tick;
        check("ca_rvalid", ca_rvalid, 1);
        check("ca_rdata", ca_rdata, 16'h1234);
        tick;
        check("ca_rvalid_pulse", ca_rvalid, 0);
        check("ww_mem", {model_rd(18'h00300), model_rd(18'h00301)}, {16'hAAAA, 16'hBBBB});

        // VGA arriving during a CA write waits through CA_WR and TURN only.
        ca_req = 1'b1; ca_we = 1'b1; ca_addr = 18'h00120; ca_wdata = 16'h4321;
        tick;
        check("wv_wr_strb", strb(), S_WR);
        ca_req = 1'b0; vga_req = 1'b1; vga_addr = 18'h00010;
        tick;
        check("wv_turn_strb", strb(), S_IDLE);
        tick;
        check("wv_vga_bus", {sram_addr, strb()}, {18'h00010, S_RD});
        vga_req = 1'b0;
        tick;
        check("wv_vga_data", {vga_valid, vga_data}, {1'b1, 16'hBEEF});

        // Starvation flag: CA read held off by continuous VGA traffic.
        vga_req = 1'b1; vga_addr = 18'h00010;
        ca_req = 1'b1; ca_we = 1'b0; ca_addr = 18'h01000;
        sgnt = 0;
        for (int k = 1; k <= 1030; k++) begin
            tick;
            if (k == 1022) check("starve_1022", ca_starve, 0);
            if (k == 1023) check("starve_1023", ca_starve, 1);
            if (ca_gnt) sgnt++;
        end
        check("starve_no_gnt", sgnt, 0);
        check("starve_held", ca_starve, 1);
        vga_req = 1'b0;
        tick;
        check("starve_gnt", {ca_gnt, ca_starve, vga_valid, ca_rvalid}, 4'b1110);
        ca_req = 1'b0;
        tick;
        check("starve_clear", {ca_starve, ca_rvalid, vga_valid}, 3'b010);
        check("starve_rdata", ca_rdata, 16'h4A5A);

        // Reset in the middle of a write, then in the middle of a read.
        ca_req = 1'b1; ca_we = 1'b1; ca_addr = 18'h00140; ca_wdata = 16'h9999;
        tick;
        check("rw_wr_strb", strb(), S_WR);
        rst_n = 1'b0; ca_req = 1'b0;
        tick;
        check("rw_strb", strb(), S_IDLE);
        check("rw_pulses", {ca_gnt, ca_rvalid}, 0);
        rst_n = 1'b1;
        tick;
        ca_req = 1'b1; ca_we = 1'b0; ca_addr = 18'h00100;
        tick;
        check("rr_gnt", ca_gnt, 1);
        rst_n = 1'b0; ca_req = 1'b0;
        tick;
        check("rr_rvalid_rst", {ca_rvalid, strb()}, {1'b0, S_IDLE});
        rst_n = 1'b1;
        tick;
        check("rr_rvalid_after", {ca_rvalid, vga_valid}, 0);

        // Random mixed traffic against a scoreboard of the CA region 0x400..0x40F.
        for (int i = 0; i < 16; i++) ref_mem[i] = model_rd(18'h00400 + 18'(i));
        issued = 0; granted = 0; dup_err = 0; rd_err = 0;
        conc_err = 0; oe_err = 0; timeout = 0; wait_cyc = 0;
        for (int cyc = 0; cyc < 620; cyc++) begin
            tick;
            if (ca_gnt) begin
                if (!ca_req) begin
                    dup_err++;
                end else begin
                    granted++;
                    if (ca_we) ref_mem[ca_addr[3:0]] = ca_wdata;
                    else exp_q.push_back(ref_mem[ca_addr[3:0]]);
                    ca_req = 1'b0;
                end
            end
            if (ca_rvalid) begin
                if (exp_q.size() == 0) begin
                    rd_err++;
                end else begin
                    exp_d = exp_q.pop_front();
                    if (ca_rdata !== exp_d) rd_err++;
                end
            end
            if (vga_valid && ca_rvalid) conc_err++;
            if (!oe_n && sram_dq_oe) oe_err++;
            if (ca_req) begin
                wait_cyc++;
                if (wait_cyc > 64) begin
                    timeout++;
                    ca_req = 1'b0;
                end
            end
            if (!ca_req && (cyc < 600) && ($urandom_range(0, 2) == 0)) begin
                ca_req   = 1'b1;
                ca_we    = 1'($urandom_range(0, 1));
                ca_addr  = 18'h00400 + 18'($urandom_range(0, 15));
                ca_wdata = 16'($urandom);
                issued++;
                wait_cyc = 0;
            end
            vga_req  = (cyc < 600) ? 1'($urandom_range(0, 1)) : 1'b0;
            vga_addr = 18'h02000 + 18'($urandom_range(0, 255));
        end
        check("rand_granted", granted, issued);
        check("rand_dup_gnt", dup_err, 0);
        check("rand_rdata", rd_err, 0);
        check("rand_rd_outstanding", exp_q.size(), 0);
        check("rand_valid_overlap", conc_err, 0);
        check("rand_oe_vs_dqoe", oe_err, 0);
        check("rand_ca_timeout", timeout, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
